// File: rtl/cache_pkg.sv
// Shared cache configuration for the tag-array / replacement slice.
// Holds the default geometry (ASSOC, INDEX_SIZE, BLOCK_SIZE, ADDR_SIZE) and
// the tag-array replace-code encoding.
package cache_pkg;

  localparam int unsigned ASSOC      = 8;
  localparam int unsigned INDEX_SIZE = 7;
  localparam int unsigned BLOCK_SIZE = 16;
  localparam int unsigned ADDR_SIZE  = 32;

  // Replace code driven to the tag array.
  typedef enum logic [2:0] {
    RST     = 3'b000,
    FILL    = 3'b001,
    WB_ADDR = 3'b010,
    LD_ADDR = 3'b011
  } replace_code_e;

endpackage

// File: rtl/lru_set_update.sv
// Combinational next-age logic for one set of the age-based LRU array.
// Ports:
//   ages_in   - current ages of the set, one WAY_W field per way (0 = MRU)
//   touch     - make touch_way MRU (takes priority over inval)
//   touch_way - way being touched
//   inval     - make inval_way LRU
//   inval_way - way being invalidated
//   ages_out  - ages the set should hold after this cycle's update
//   lru       - way whose age is ASSOC-1 (0 if none exists)
//   dup       - the current ages contain a duplicate value
module lru_set_update
  import cache_pkg::*;
#(
  parameter  int unsigned ASSOC = cache_pkg::ASSOC,
  localparam int unsigned WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-1:0][WAY_W-1:0] ages_in,
  input  logic                        touch,
  input  logic [WAY_W-1:0]            touch_way,
  input  logic                        inval,
  input  logic [WAY_W-1:0]            inval_way,
  output logic [ASSOC-1:0][WAY_W-1:0] ages_out,
  output logic [WAY_W-1:0]            lru,
  output logic                        dup
);

  logic [WAY_W-1:0] touch_age;
  logic [WAY_W-1:0] inval_age;

  assign touch_age = ages_in[touch_way];
  assign inval_age = ages_in[inval_way];

  // Touch: younger ways age by one, touched way becomes 0.
  // Inval: older ways get younger by one, invalidated way becomes ASSOC-1.
  // The strict comparisons make the already-MRU / already-LRU cases no-ops
  // and keep the increments/decrements from wrapping.
  always_comb begin
    ages_out = ages_in;
    if (touch) begin
      for (int unsigned i = 0; i < ASSOC; i++) begin
        if (WAY_W'(i) == touch_way) begin
          ages_out[i] = '0;
        end else if (ages_in[i] < touch_age) begin
          ages_out[i] = ages_in[i] + 1'b1;
        end
      end
    end else if (inval) begin
      for (int unsigned i = 0; i < ASSOC; i++) begin
        if (WAY_W'(i) == inval_way) begin
          ages_out[i] = '1;
        end else if (ages_in[i] > inval_age) begin
          ages_out[i] = ages_in[i] - 1'b1;
        end
      end
    end
  end

  // ASSOC is a power of two, so age ASSOC-1 is the all-ones value.
  always_comb begin
    lru = '0;
    for (int unsigned i = 0; i < ASSOC; i++) begin
      if (ages_in[i] == '1) begin
        lru = WAY_W'(i);
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < ASSOC; i++) begin
      for (int unsigned j = i + 1; j < ASSOC; j++) begin
        if (ages_in[i] == ages_in[j]) begin
          dup = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lru_array.sv
// Age-based LRU replacement state for a set-associative cache.
// Each set holds one age per way (0 = MRU, ASSOC-1 = LRU); the ages of a set
// always form a permutation of 0..ASSOC-1.
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset; every set loads age[i] = i
//   index     - set selected for lookup and update
//   touch     - mark touch_way MRU in the indexed set (wins over inval)
//   touch_way - way accessed on a hit / filled on a miss
//   inval     - mark inval_way LRU in the indexed set
//   inval_way - way being invalidated
//   lru       - victim way of the indexed set, combinational from stored state
//   age_err   - sticky flag: indexed set's ages were seen with a duplicate
module lru_array
  import cache_pkg::*;
#(
  parameter  int unsigned ASSOC      = cache_pkg::ASSOC,
  parameter  int unsigned INDEX_SIZE = cache_pkg::INDEX_SIZE,
  localparam int unsigned WAY_W      = $clog2(ASSOC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_SIZE-1:0] index,
  input  logic                  touch,
  input  logic [WAY_W-1:0]      touch_way,
  input  logic                  inval,
  input  logic [WAY_W-1:0]      inval_way,
  output logic [WAY_W-1:0]      lru,
  output logic                  age_err
);

  localparam int unsigned SETS = 2 ** INDEX_SIZE;

  logic [ASSOC-1:0][WAY_W-1:0] ages_q [SETS];
  logic [ASSOC-1:0][WAY_W-1:0] cur_ages;
  logic [ASSOC-1:0][WAY_W-1:0] next_ages;
  logic                        dup;

  assign cur_ages = ages_q[index];

  lru_set_update #(
    .ASSOC (ASSOC)
  ) u_set_update (
    .ages_in   (cur_ages),
    .touch     (touch),
    .touch_way (touch_way),
    .inval     (inval),
    .inval_way (inval_way),
    .ages_out  (next_ages),
    .lru       (lru),
    .dup       (dup)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned i = 0; i < ASSOC; i++) begin
          ages_q[s][i] <= WAY_W'(i);
        end
      end
      age_err <= 1'b0;
    end else begin
      if (touch || inval) begin
        ages_q[index] <= next_ages;
      end
      if (dup) begin
        age_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lru_array.sv
// Self-checking bench for lru_array. The reference keeps each set as a queue
// of way numbers ordered MRU..LRU; touch moves a way to the front, inval to
// the back, and the victim is the last entry.
module tb_lru_array;

  localparam int unsigned ASSOC      = 8;
  localparam int unsigned INDEX_SIZE = 7;
  localparam int unsigned WAY_W      = 3;
  localparam int unsigned SETS       = 128;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [INDEX_SIZE-1:0] index = '0;
  logic                  touch = 1'b0;
  logic [WAY_W-1:0]      touch_way = '0;
  logic                  inval = 1'b0;
  logic [WAY_W-1:0]      inval_way = '0;
  logic [WAY_W-1:0]      lru;
  logic                  age_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          ready = 1'b0;

  int unsigned ord [SETS][$];

  always #5 clk = ~clk;

  lru_array #(
    .ASSOC      (ASSOC),
    .INDEX_SIZE (INDEX_SIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (index),
    .touch     (touch),
    .touch_way (touch_way),
    .inval     (inval),
    .inval_way (inval_way),
    .lru       (lru),
    .age_err   (age_err)
  );

  function automatic logic [31:0] model_lru(int unsigned s);
    return 32'(ord[s][ASSOC-1]);
  endfunction

  task automatic move(int unsigned s, int unsigned w, bit to_front);
    int unsigned p = 0;
    for (int unsigned k = 0; k < ord[s].size(); k++)
      if (ord[s][k] == w) p = k;
    ord[s].delete(p);
    if (to_front) ord[s].push_front(w);
    else          ord[s].push_back(w);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (index %0d, t=%0t)", name, act, exp, index, $time);
    end
  endtask

  // Reference update on the same edge the DUT samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        ord[s].delete();
        for (int unsigned i = 0; i < ASSOC; i++) ord[s].push_back(i);
      end
      ready = 1'b1;
    end else if (ready) begin
      if (touch)      move(int'(index), int'(touch_way), 1'b1);
      else if (inval) move(int'(index), int'(inval_way), 1'b0);
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    #2;
    if (ready) begin
      chk("lru", 32'(lru), model_lru(int'(index)));
      chk("age_err", 32'(age_err), 32'd0);
    end
  end

  task automatic step(int unsigned idx, bit t, int unsigned tw, bit iv, int unsigned iw, bit rn);
    @(negedge clk);
    rst_n     = rn;
    index     = INDEX_SIZE'(idx);
    touch     = t;
    touch_way = WAY_W'(tw);
    inval     = iv;
    inval_way = WAY_W'(iw);
    #3;
  endtask

  task automatic nop(int unsigned idx);
    step(idx, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  // Hand-derived expectation that pins both the DUT and the reference.
  task automatic lit(string name, int unsigned exp);
    chk(name, 32'(lru), 32'(exp));
    chk({name, "_model"}, model_lru(int'(index)), 32'(exp));
  endtask

  initial begin
    step(0, 1'b0, 0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 0, 1'b0, 0, 1'b0);

    nop(5);
    lit("reset_lru", 7);
    chk("reset_err", 32'(age_err), 32'd0);

    step(5, 1'b1, 7, 1'b0, 0, 1'b1);
    lit("no_forward", 7);
    nop(5);
    lit("touch7_lru", 6);
    nop(6);
    lit("other_set", 7);

    for (int unsigned w = 0; w < ASSOC; w++) step(9, 1'b1, w, 1'b0, 0, 1'b1);
    nop(9);
    lit("all_touched", 0);
    step(9, 1'b1, 0, 1'b0, 0, 1'b1);
    nop(9);
    lit("retouch0", 1);
    step(9, 1'b0, 0, 1'b1, 3, 1'b1);
    nop(9);
    lit("inval3", 3);
    step(9, 1'b0, 0, 1'b1, 3, 1'b1);
    nop(9);
    lit("inval_lru_noop", 3);
    step(9, 1'b1, 3, 1'b0, 0, 1'b1);
    nop(9);
    lit("touch_after_inval", 1);
    step(9, 1'b1, 3, 1'b0, 0, 1'b1);
    nop(9);
    lit("touch_mru_noop", 1);

    step(12, 1'b1, 2, 1'b1, 4, 1'b1);
    nop(12);
    lit("touch_prio", 7);
    step(12, 1'b1, 7, 1'b0, 0, 1'b1);
    nop(12);
    lit("touch_prio_next", 6);

    step(20, 1'b1, 7, 1'b0, 0, 1'b1);
    step(20, 1'b1, 6, 1'b0, 0, 1'b0);
    nop(20);
    lit("rst_discard", 7);
    nop(5);
    lit("rst_set5", 7);
    nop(9);
    lit("rst_set9", 7);

    for (int n = 0; n < 4000; n++) begin
      int unsigned idx;
      idx = ($urandom % 8 == 0) ? ($urandom % SETS) : ($urandom % 8);
      step(idx, ($urandom % 10) < 4, $urandom % ASSOC,
           ($urandom % 10) < 3, $urandom % ASSOC, ($urandom % 600) != 0);
    end
    nop(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
